accel_mem_arbiter: RTL and testbench
====================================

Name: accel_mem_arbiter

Overview:
- Parametrised N-channel arbiter sitting between the accelerator block and the CPU memory port.
- Lets several accelerator clusters share the single read/write data-memory interface.
- Successor to the current fixed single-channel hookup, where read and write share one address. Adds:
  - per-channel request/response routing
  - fair round-robin grant
  - an optional response watchdog

Parameters:
NUM_CH, 4, number of requesting channels (2..16)
ADDR_W, 16, memory address width
WDATA_W, 32, write data width
RDATA_W, 512, read data width (one cache line)
TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  sole clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
ch_rd_en  in  NUM_CH  per-channel read request, level, held until ch_rd_valid
ch_wr_en  in  NUM_CH  per-channel write request, level, held until ch_wr_done
ch_addr  in  NUM_CH*ADDR_W  per-channel address, channel i at [i*ADDR_W +: ADDR_W]
ch_wr_data  in  NUM_CH*WDATA_W  per-channel write data, same packing
ch_rd_data  out  RDATA_W  registered read data, shared, valid with ch_rd_valid
ch_rd_valid  out  NUM_CH  one-cycle pulse to the granted channel on read completion
ch_wr_done  out  NUM_CH  one-cycle pulse to the granted channel on write completion
ch_err  out  NUM_CH  one-cycle pulse on watchdog abort (tied 0 without macro)
grant_id  out  $clog2(NUM_CH)  index of the current/last granted channel
busy  out  1  high whenever the FSM is not IDLE
mem_rd_en  out  1  one-cycle read command to the memory port
mem_wr_en  out  1  one-cycle write command to the memory port
mem_addr  out  ADDR_W  command address, held stable from ISSUE until the response
mem_wr_data  out  WDATA_W  write data, held with mem_addr
mem_rd_data  in  RDATA_W  read data from the memory port
mem_rd_valid  in  1  read completion pulse
mem_wr_done  in  1  write completion pulse

Behaviour:
- Reset (rst=1 at a clock edge):
  - FSM to IDLE.
  - All outputs are 0: ch_rd_data, ch_rd_valid, ch_wr_done, ch_err, mem_*, busy.
  - grant_id=NUM_CH-1, so the first grant after reset goes to channel 0.
  - Watchdog counter = 0.
- Reset mid-transaction aborts it silently. No response is sent to the channel, and late memory responses are ignored.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - req[i] = ch_rd_en[i] | ch_wr_en[i].
  - If any req is set, grant the first set index searching from grant_id+1 upward, wrapping modulo NUM_CH.
  - Latch into the command registers:
    - address and write data of the granted channel
    - op = write if ch_wr_en[g], else read (write wins when a channel asserts both)
  - Update grant_id, go to ISSUE.
  - If no req, stay in IDLE.
- ISSUE:
  - Pulse mem_wr_en or mem_rd_en for exactly one cycle.
  - mem_addr and mem_wr_data are driven from the latched registers.
  - Go to WAIT.
- WAIT:
  - Hold mem_addr and mem_wr_data; mem_*_en stay 0.
  - Read op: on mem_rd_valid, register mem_rd_data into ch_rd_data and go to RESP.
  - Write op: on mem_wr_done, go to RESP.
  - A completion pulse of the wrong type is ignored.
- RESP:
  - Pulse ch_rd_valid[g] or ch_wr_done[g] for one cycle. ch_rd_data is valid that same cycle and held until the next read completes.
  - Go to IDLE.
- Latency:
  - Request sampled in IDLE at cycle T; mem_*_en at T+1.
  - Memory response at cycle R; channel pulse at R+1.
  - Minimum request-to-next-grant spacing is 4 cycles.
- Requests must stay asserted until their response. A channel that deasserts early still completes its latched transaction and receives the pulse.
- mem_rd_valid or mem_wr_done outside WAIT is ignored.
- A single requester may be re-granted back-to-back. Fairness: each requesting channel is served within NUM_CH grants.

Optional Feature:
- Macro ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT, cleared on entry to WAIT.
  - When it reaches TIMEOUT_CYC with no matching response:
    - pulse ch_err[g] for one cycle (no rd_valid or wr_done)
    - return to IDLE
    - ignore any later response for that transaction
- Macro ARB_TIMEOUT_EN undefined:
  - No counter is built, ch_err is constant 0, and WAIT waits indefinitely.

Test Plan:
- Reset, then ch_wr_en=4'b0001, addr0=0x0040, data0=0xDEADBEEF, mem_wr_done 3 cycles after mem_wr_en -> mem_wr_en one cycle, mem_addr=0x0040, mem_wr_data=0xDEADBEEF, ch_wr_done=4'b0001 one cycle after mem_wr_done, grant_id=0.
- ch_rd_en=4'b0010, addr1=0x1000, mem_rd_valid with mem_rd_data=512'hA5..A5 -> ch_rd_valid=4'b0010 next cycle, ch_rd_data=512'hA5..A5, other channels see no pulse.
- All 4 channels hold write requests continuously -> grant order 0,1,2,3,0, with exactly one ch_wr_done per grant.
- Channel 2 asserts ch_rd_en and ch_wr_en together -> mem_wr_en issued first; the read is served on channel 2's next grant.
- rst pulsed while in WAIT, then stray mem_rd_valid -> all outputs 0, busy=0, no ch_rd_valid; next request goes to channel 0.
- With ARB_TIMEOUT_EN and TIMEOUT_CYC=16, a read with no mem_rd_valid -> ch_err[g] pulses 16 cycles after entering WAIT, FSM returns to IDLE, and a later mem_rd_valid is ignored.

Source files
------------

// File: rtl/accel_mem_arbiter.sv
// accel_mem_arbiter: round-robin N-channel arbiter onto one memory port; define ARB_TIMEOUT_EN for the response watchdog
module accel_mem_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 16,
  parameter int WDATA_W     = 32,
  parameter int RDATA_W     = 512,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           ch_rd_en,
  input  logic [NUM_CH-1:0]           ch_wr_en,
  input  logic [NUM_CH*ADDR_W-1:0]    ch_addr,
  input  logic [NUM_CH*WDATA_W-1:0]   ch_wr_data,
  output logic [RDATA_W-1:0]          ch_rd_data,
  output logic [NUM_CH-1:0]           ch_rd_valid,
  output logic [NUM_CH-1:0]           ch_wr_done,
  output logic [NUM_CH-1:0]           ch_err,
  output logic [$clog2(NUM_CH)-1:0]   grant_id,
  output logic                        busy,
  output logic                        mem_rd_en,
  output logic                        mem_wr_en,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [WDATA_W-1:0]          mem_wr_data,
  input  logic [RDATA_W-1:0]          mem_rd_data,
  input  logic                        mem_rd_valid,
  input  logic                        mem_wr_done
);
  localparam int GW = $clog2(NUM_CH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t              r_state;
  logic [GW-1:0]       r_gid, w_gnt, w_idx;
  logic [NUM_CH-1:0]   w_req, w_oh, r_rd_valid, r_wr_done;
  logic                r_wr_op, r_mem_rd_en, r_mem_wr_en, w_hit;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [WDATA_W-1:0]  r_mem_wdata;
  logic [RDATA_W-1:0]  r_rd_data;
  if (NUM_CH < 2 || NUM_CH > 16 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("accel_mem_arbiter: parameter out of range");
  end
  // round-robin pick: scanning from farthest to nearest leaves the nearest requester after the last grant
  always_comb begin
    w_req = ch_rd_en | ch_wr_en;
    w_gnt = r_gid;
    w_idx = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_idx = GW'((int'(r_gid) + k) % NUM_CH);
      if (w_req[w_idx]) w_gnt = w_idx;
    end
  end
  assign w_oh  = NUM_CH'(1) << r_gid;
  assign w_hit = r_wr_op ? mem_wr_done : mem_rd_valid;
`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0]     r_wdog;
  logic [NUM_CH-1:0] r_err;
  logic              w_tout;
  assign w_tout = (r_wdog == TW'(TIMEOUT_CYC - 1));
  assign ch_err = r_err;
`else
  assign ch_err = '0;
`endif
  // transaction FSM; command and response pulses are registered on the transition that enters their state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_gid       <= GW'(NUM_CH - 1);
      r_wr_op     <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_mem_wr_en <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= '0;
      r_wr_done   <= '0;
`ifdef ARB_TIMEOUT_EN
      r_wdog      <= '0;
      r_err       <= '0;
`endif
    end else begin
      r_mem_rd_en <= 1'b0;
      r_mem_wr_en <= 1'b0;
      r_rd_valid  <= '0;
      r_wr_done   <= '0;
`ifdef ARB_TIMEOUT_EN
      r_err       <= '0;
`endif
      case (r_state)
        IDLE: if (|w_req) begin
          r_gid       <= w_gnt;
          r_wr_op     <= ch_wr_en[w_gnt];
          r_mem_wr_en <= ch_wr_en[w_gnt];
          r_mem_rd_en <= !ch_wr_en[w_gnt];
          r_mem_addr  <= ch_addr[int'(w_gnt)*ADDR_W +: ADDR_W];
          r_mem_wdata <= ch_wr_data[int'(w_gnt)*WDATA_W +: WDATA_W];
          r_state     <= ISSUE;
        end
        ISSUE: begin
`ifdef ARB_TIMEOUT_EN
          r_wdog  <= '0;
`endif
          r_state <= WAIT;
        end
        WAIT: begin
`ifdef ARB_TIMEOUT_EN
          r_wdog <= r_wdog + 1'b1;
`endif
          if (w_hit) begin
            if (!r_wr_op) r_rd_data <= mem_rd_data;
            r_rd_valid <= r_wr_op ? '0 : w_oh;
            r_wr_done  <= r_wr_op ? w_oh : '0;
            r_state    <= RESP;
          end
`ifdef ARB_TIMEOUT_EN
          else if (w_tout) begin
            r_err   <= w_oh;
            r_state <= IDLE;
          end
`endif
        end
        RESP: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign ch_rd_data  = r_rd_data;
  assign ch_rd_valid = r_rd_valid;
  assign ch_wr_done  = r_wr_done;
  assign grant_id    = r_gid;
  assign busy        = (r_state != IDLE);
  assign mem_rd_en   = r_mem_rd_en;
  assign mem_wr_en   = r_mem_wr_en;
  assign mem_addr    = r_mem_addr;
  assign mem_wr_data = r_mem_wdata;
endmodule

// File: tb/tb_accel_mem_arbiter.sv
// tb_accel_mem_arbiter: scoreboard bench for accel_mem_arbiter with a delayed-response memory model
module tb_accel_mem_arbiter;
  localparam int N = 4, AW = 16, DW = 32, RW = 512, TO = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] ch_rd_en = '0, ch_wr_en = '0;
  logic [N*AW-1:0] ch_addr = '0;
  logic [N*DW-1:0] ch_wr_data = '0;
  logic [RW-1:0] ch_rd_data, mem_rd_data = '0;
  logic [N-1:0] ch_rd_valid, ch_wr_done, ch_err;
  logic [1:0] grant_id;
  logic busy, mem_rd_en, mem_wr_en;
  logic mem_rd_valid = 1'b0, mem_wr_done = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  typedef struct {int ch; bit wr; bit err; logic [AW-1:0] addr; logic [DW-1:0] wd; logic [RW-1:0] rd;} exp_t;
  exp_t exp_q[$];
  int total = 0, bad = 0, n_pulse = 0, cyc = 0, rcyc = 0, ccyc = 0, pend = 0, dly = 3, base = 0;
  bit mute = 1'b1, own = 1'b0, pw = 1'b0, prev_en = 1'b0, prev_p = 1'b0, s_rv = 1'b0, s_wd = 1'b0;
  logic [RW-1:0] prd = '0, s_data = '0, rd1, rd2, rd3;

  accel_mem_arbiter #(.NUM_CH(N), .ADDR_W(AW), .WDATA_W(DW), .RDATA_W(RW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .ch_rd_en(ch_rd_en), .ch_wr_en(ch_wr_en), .ch_addr(ch_addr),
    .ch_wr_data(ch_wr_data), .ch_rd_data(ch_rd_data), .ch_rd_valid(ch_rd_valid),
    .ch_wr_done(ch_wr_done), .ch_err(ch_err), .grant_id(grant_id), .busy(busy),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .mem_wr_done(mem_wr_done));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // memory model and scoreboard: sampled on the falling edge, away from DUT updates
  initial begin
    exp_t e;
    logic [N-1:0] oh;
    forever begin
      @(negedge clk);
      cyc++;
      if (own) begin
        mem_rd_valid = 1'b0;
        mem_wr_done = 1'b0;
        own = 1'b0;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          own = 1'b1;
          if (pw) mem_wr_done = 1'b1;
          else begin
            mem_rd_data = prd;
            mem_rd_valid = 1'b1;
          end
          if (exp_q.size() > 0) check("hold_addr", mem_addr, exp_q[0].addr);
        end
      end
      if (s_rv) begin
        mem_rd_data = s_data;
        mem_rd_valid = 1'b1;
        own = 1'b1;
        s_rv = 1'b0;
      end
      if (s_wd) begin
        mem_wr_done = 1'b1;
        own = 1'b1;
        s_wd = 1'b0;
      end
      if (mem_rd_valid || mem_wr_done) rcyc = cyc;
      if (mem_rd_en || mem_wr_en) begin
        check("en_1cyc", prev_en, 0);
        ccyc = cyc;
        if (exp_q.size() == 0) check("unexp_cmd", 1, 0);
        else begin
          e = exp_q[0];
          check("mem_op", {mem_wr_en, mem_rd_en}, e.wr ? 2'b10 : 2'b01);
          check("mem_addr", mem_addr, e.addr);
          if (e.wr) check("mem_wr_data", mem_wr_data, e.wd);
          check("cmd_grant", grant_id, e.ch);
          pw = e.wr;
          prd = e.rd;
          pend = mute ? 0 : dly;
        end
      end
      if (|{ch_rd_valid, ch_wr_done, ch_err}) begin
        n_pulse++;
        check("pulse_1cyc", prev_p, 0);
        if (exp_q.size() == 0) check("unexp_pulse", {ch_err, ch_wr_done, ch_rd_valid}, 0);
        else begin
          e = exp_q.pop_front();
          oh = N'(1) << e.ch;
          check("ch_rd_valid", ch_rd_valid, (e.err || e.wr) ? N'(0) : oh);
          check("ch_wr_done", ch_wr_done, (!e.err && e.wr) ? oh : N'(0));
          check("ch_err", ch_err, e.err ? oh : N'(0));
          check("resp_grant", grant_id, e.ch);
          if (!e.err && !e.wr) check("ch_rd_data", ch_rd_data, e.rd);
          if (e.err) check("err_lat", cyc - ccyc, TO + 1);
          else check("resp_lat", cyc - rcyc, 1);
        end
      end
      prev_en = mem_rd_en | mem_wr_en;
      prev_p = |{ch_rd_valid, ch_wr_done, ch_err};
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input bit wr, input bit err, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [RW-1:0] r);
    exp_t e;
    e.ch = ch; e.wr = wr; e.err = err; e.addr = a; e.wd = d; e.rd = r;
    exp_q.push_back(e);
    ch_addr[ch*AW +: AW] = a;
    ch_wr_data[ch*DW +: DW] = d;
  endtask

  task automatic wait_pulses(input int target);
    int n = 0;
    while (n_pulse < target && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("pulse_wait", n_pulse >= target, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ch_rd_en = '0;
    ch_wr_en = '0;
    exp_q.delete();
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic check_reset();
    check("rst_busy", busy, 0);
    check("rst_gid", grant_id, N - 1);
    check("rst_mem_en", {mem_rd_en, mem_wr_en}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wd", mem_wr_data, 0);
    check("rst_pulses", {ch_rd_valid, ch_wr_done, ch_err}, 0);
    check("rst_rd_data", ch_rd_data, 0);
  endtask

  initial begin
    for (int i = 0; i < RW / 32; i++) begin
      rd2[i*32 +: 32] = $urandom;
      rd3[i*32 +: 32] = $urandom;
    end
    rd1 = {64{8'hA5}};
    #1;
    do_reset();
    check_reset();
    mute = 1'b0;
    push(0, 1, 0, 16'h0040, 32'hDEADBEEF, '0);
    ch_wr_en[0] = 1'b1;
    wait_pulses(1);
    ch_wr_en[0] = 1'b0;
    check("gid_wr0", grant_id, 0);
    push(1, 0, 0, 16'h1000, '0, rd1);
    ch_rd_en[1] = 1'b1;
    wait_pulses(2);
    ch_rd_en[1] = 1'b0;
    tick(3);
    check("rd_data_hold", ch_rd_data, rd1);
    mute = 1'b1;
    do_reset();
    check_reset();
    mute = 1'b0;
    base = n_pulse;
    for (int i = 0; i < 5; i++) push(i % N, 1, 0, AW'(16'h2000 + (i % N) * 16), 32'hC0DE0000 + DW'(i % N), '0);
    ch_wr_en = '1;
    wait_pulses(base + 5);
    ch_wr_en = '0;
    tick(6);
    check("fair_idle", busy, 0);
    check("fair_q", exp_q.size(), 0);
    base = n_pulse;
    push(2, 1, 0, 16'h2BEE, 32'h12345678, '0);
    push(2, 0, 0, 16'h2BEE, 32'h12345678, rd2);
    ch_rd_en[2] = 1'b1;
    ch_wr_en[2] = 1'b1;
    wait_pulses(base + 1);
    ch_wr_en[2] = 1'b0;
    wait_pulses(base + 2);
    ch_rd_en[2] = 1'b0;
    tick(2);
    base = n_pulse;
    mute = 1'b1;
`ifdef ARB_TIMEOUT_EN
    push(3, 0, 1, 16'h3300, '0, '0);
    ch_rd_en[3] = 1'b1;
    wait_pulses(base + 1);
    ch_rd_en[3] = 1'b0;
    tick(2);
    s_data = '1;
    s_rv = 1'b1;
    tick(4);
    check("to_idle", busy, 0);
    check("to_rd_data", ch_rd_data, rd2);
`else
    push(3, 0, 0, 16'h3300, '0, rd3);
    ch_rd_en[3] = 1'b1;
    tick(40);
    check("wait_busy", busy, 1);
    check("no_err", ch_err, 0);
    s_wd = 1'b1;
    tick(4);
    check("wrong_type_busy", busy, 1);
    s_data = rd3;
    s_rv = 1'b1;
    wait_pulses(base + 1);
    ch_rd_en[3] = 1'b0;
`endif
    tick(2);
    push(1, 0, 0, 16'h1111, '0, '0);
    ch_rd_en[1] = 1'b1;
    tick(8);
    check("pre_rst_busy", busy, 1);
    do_reset();
    check_reset();
    s_data = '1;
    s_rv = 1'b1;
    tick(4);
    check_reset();
    mute = 1'b0;
    base = n_pulse;
    push(0, 1, 0, 16'h0A0A, 32'h0A0A0A0A, '0);
    push(2, 1, 0, 16'h0C0C, 32'h0C0C0C0C, '0);
    ch_wr_en = 4'b0101;
    wait_pulses(base + 1);
    ch_wr_en[0] = 1'b0;
    wait_pulses(base + 2);
    ch_wr_en[2] = 1'b0;
    tick(5);
    check("q_empty", exp_q.size(), 0);
    check("end_idle", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
